dac_spi_tx: RTL and testbench
=============================

// Module: dac_spi_tx
// PURPOSE
//  Downstream stage of the echo processor. Takes each 10-bit output sample (data_out, offset binary)
//  and serialises it into a 16-bit SPI write frame for an MCP4911-class 10-bit DAC.
//  Drives CS, SCK, SDI and LDAC. Frame rate is set by the upstream sample strobe (load).
//  Reports busy, done and overrun so sample drops are visible.
// PARAMETERS
//  CLK_DIV   25       sysclk cycles per SCK half-period (50 MHz sysclk -> 1 MHz SCK); legal range >= 1
//  CFG_BITS  4'b0011  frame bits [15:12] = {A/B(=0), BUF, GA_n, SHDN_n}
// PORTS
//  sysclk    in   1   system clock; all logic on posedge
//  reset     in   1   synchronous, active-high reset
//  data_in   in   10  sample to convert, offset binary (0x200 = mid-scale)
//  load      in   1   1-cycle strobe: data_in valid this cycle
//  busy      out  1   high while a frame (or queued frame) is in progress
//  done      out  1   1-cycle pulse when a frame's LDAC pulse completes
//  overrun   out  1   1-cycle pulse when a load is dropped
//  dac_cs    out  1   SPI chip select, active low
//  dac_sck   out  1   SPI clock, idle low; DAC samples SDI on rising edge
//  dac_sdi   out  1   SPI data, MSB first
//  dac_ld    out  1   LDAC, active low
// BEHAVIOUR
//  Reset: dac_cs=1, dac_sck=0, dac_sdi=0, dac_ld=1, busy=0, done=0, overrun=0, state=IDLE.
//    All internal counters and queue are cleared. Reset wins over load in the same cycle.
//    Reset mid-frame aborts the frame; the pins return to idle on the next edge.
//  Frame: {CFG_BITS, data[9:0], 2'b00}, transmitted MSB first. data is latched on the accepting edge.
//  FSM:
//   - IDLE: load=1 -> CS_SETUP. dac_cs=0 and busy=1 from the next cycle.
//   - CS_SETUP: lasts CLK_DIV cycles; dac_sck=0; dac_sdi = frame[15].
//   - SHIFT: 16 bits, each 2*CLK_DIV cycles. sck is low for CLK_DIV cycles, then high for CLK_DIV cycles.
//     dac_sdi changes only while sck is low, at the first cycle of each bit.
//     After bit 0's high phase -> CS_HOLD.
//   - CS_HOLD: lasts CLK_DIV cycles; cs=0, sck=0.
//   - LDAC: lasts CLK_DIV cycles; cs=1, ld=0. Exit -> IDLE; done=1 for exactly one cycle.
//  Timing: busy is high for exactly 35*CLK_DIV cycles per frame. Load-to-first-SCK-rise = 1+2*CLK_DIV cycles.
//  Counters: the divider counter width is $clog2(CLK_DIV)+1. The bit counter is 4 bits and counts 15 down to 0.
//  Load while busy: see CONFIGURATION. A load during the done cycle (IDLE) is accepted normally.
//  Data passes unmodified: no offset or saturation is applied; upstream owns the arithmetic.
// CONFIGURATION
//  DAC_LOAD_QUEUE_EN defined:
//   - A one-entry pending register captures a load that arrives while busy.
//   - At LDAC exit, done pulses and the FSM goes straight to CS_SETUP with the pending sample.
//     busy stays high and the pending register clears.
//   - A load while pending is already full overwrites it with the newest sample and pulses overrun.
//  DAC_LOAD_QUEUE_EN undefined:
//   - There is no pending register. A load while busy is dropped and overrun pulses 1 cycle.
//   - The in-flight frame is unaffected.
// TESTING  (CLK_DIV=2 unless noted)
//  - Reset, then load with data_in=0x2AA -> SDI sequence 0011_1010_1010_1000 across 16 SCK rises; busy=70 cycles; one done pulse.
//  - Samples 0x000 and 0x3FF -> frame bits [11:2] are all 0 and all 1 respectively; cs low exactly 16 SCK rises; ld low 2 cycles after cs rises.
//  - Load at cycle 10 of a frame, macro off -> overrun pulse in the next cycle; the frame completes with the original data; no second frame.
//  - Same as above with the macro on -> the second frame starts immediately after the first done pulse, carrying the new data.
//    A third load in the same frame -> overrun, and the newest data is sent.
//  - Reset asserted mid-SHIFT (bit 7) -> next cycle cs=1, sck=0, ld=1, busy=0; a new load then produces a clean full frame.
//  - CLK_DIV=1 with back-to-back loads at 40-cycle spacing -> 35-cycle busy each; SCK period = 2 cycles; no overrun.

Source files
------------

// File: rtl/dac_spi_tx.sv
// rtl/dac_spi_tx.sv - serialises 10-bit samples into 16-bit MCP4911 SPI write frames with LDAC strobe.
// DAC_LOAD_QUEUE_EN adds a one-entry pending sample register for loads arriving while busy.
module dac_spi_tx #(
  parameter int          CLK_DIV  = 25,
  parameter logic [3:0]  CFG_BITS = 4'b0011
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic [9:0] data_in,
  input  logic       load,
  output logic       busy,
  output logic       done,
  output logic       overrun,
  output logic       dac_cs,
  output logic       dac_sck,
  output logic       dac_sdi,
  output logic       dac_ld
);

  localparam int             DW       = $clog2(CLK_DIV) + 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CS_SETUP = 3'd1,
    SHIFT    = 3'd2,
    CS_HOLD  = 3'd3,
    LDAC     = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] div_cnt;
  logic          sck_high;
  logic [3:0]    bit_cnt;
  logic [15:0]   shreg;
  logic          div_end;
  logic          start;
  logic [9:0]    start_data;
  logic          ovr_nxt;

`ifdef DAC_LOAD_QUEUE_EN
  logic          pend_valid;
  logic [9:0]    pend_data;
`endif

  assign div_end = (div_cnt == DIV_LAST);

  always_ff @(posedge sysclk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    start_data = data_in;
    ovr_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          state_nxt = CS_SETUP;
          start     = 1'b1;
        end
      end
      CS_SETUP: if (div_end) state_nxt = SHIFT;
      SHIFT:    if (div_end && sck_high && (bit_cnt == 4'd0)) state_nxt = CS_HOLD;
      CS_HOLD:  if (div_end) state_nxt = LDAC;
      LDAC: begin
        if (div_end) begin
          state_nxt = IDLE;
`ifdef DAC_LOAD_QUEUE_EN
          // A load landing on the exit cycle is newer than anything pending.
          if (load || pend_valid) begin
            state_nxt = CS_SETUP;
            start     = 1'b1;
            if (!load) start_data = pend_data;
          end
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
`ifdef DAC_LOAD_QUEUE_EN
    if (load && (state != IDLE)) ovr_nxt = pend_valid;
`else
    if (load && (state != IDLE)) ovr_nxt = 1'b1;
`endif
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      div_cnt  <= '0;
      sck_high <= 1'b0;
      bit_cnt  <= 4'd0;
      shreg    <= 16'd0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      done    <= (state == LDAC) && div_end;
      overrun <= ovr_nxt;
      if (start) begin
        shreg    <= {CFG_BITS, start_data, 2'b00};
        div_cnt  <= '0;
        sck_high <= 1'b0;
        bit_cnt  <= 4'd15;
      end else if (state != IDLE) begin
        div_cnt <= div_end ? '0 : div_cnt + 1'b1;
        // Advance to the next bit only at the end of a high phase so SDI moves while SCK is low.
        if ((state == SHIFT) && div_end) begin
          sck_high <= !sck_high;
          if (sck_high && (bit_cnt != 4'd0)) begin
            bit_cnt <= bit_cnt - 4'd1;
            shreg   <= {shreg[14:0], 1'b0};
          end
        end
      end
    end
  end

`ifdef DAC_LOAD_QUEUE_EN
  always_ff @(posedge sysclk) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_data  <= 10'd0;
    end else if ((state == LDAC) && div_end) begin
      pend_valid <= 1'b0;
    end else if (load && (state != IDLE)) begin
      pend_valid <= 1'b1;
      pend_data  <= data_in;
    end
  end
`endif

  assign busy    = (state != IDLE);
  assign dac_cs  = !((state == CS_SETUP) || (state == SHIFT) || (state == CS_HOLD));
  assign dac_sck = (state == SHIFT) && sck_high;
  assign dac_sdi = ((state == CS_SETUP) || (state == SHIFT)) ? shreg[15] : 1'b0;
  assign dac_ld  = (state != LDAC);

endmodule

// File: tb/tb_dac_spi_tx.sv
// tb/tb_dac_spi_tx.sv - directed self-checking bench for dac_spi_tx (CLK_DIV=2 and CLK_DIV=1 instances).
module tb_dac_spi_tx;

  logic       sysclk = 1'b0;
  logic       reset;
  logic [9:0] data_in;
  logic       load;
  logic       busy, done, overrun, dac_cs, dac_sck, dac_sdi, dac_ld;

  logic [9:0] data_b;
  logic       load_b;
  logic       busy_b, done_b, overrun_b, cs_b, sck_b, sdi_b, ld_b;

  int checks   = 0;
  int failures = 0;

  int          f_nrise, f_busy, f_first_rise, f_ld_low, f_novr, f_ovr_idx, f_ndone;
  int          f_cs_rise_idx, f_ld_fall_idx, f_timeout;
  logic [15:0] f_bits;

  dac_spi_tx #(.CLK_DIV(2), .CFG_BITS(4'b0011)) dut (
    .sysclk(sysclk), .reset(reset), .data_in(data_in), .load(load),
    .busy(busy), .done(done), .overrun(overrun),
    .dac_cs(dac_cs), .dac_sck(dac_sck), .dac_sdi(dac_sdi), .dac_ld(dac_ld)
  );

  dac_spi_tx #(.CLK_DIV(1), .CFG_BITS(4'b0011)) dut_b (
    .sysclk(sysclk), .reset(reset), .data_in(data_b), .load(load_b),
    .busy(busy_b), .done(done_b), .overrun(overrun_b),
    .dac_cs(cs_b), .dac_sck(sck_b), .dac_sdi(sdi_b), .dac_ld(ld_b)
  );

  always #5 sysclk = ~sysclk;

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [9:0] d);
    data_in = d;
    load    = 1'b1;
    tick();
    load    = 1'b0;
  endtask

  // Starts at sample 1 of a frame; returns at the sample where done is seen.
  task automatic watch(input int inj1, input logic [9:0] d1, input int inj2, input logic [9:0] d2);
    logic prev_sck, prev_cs, prev_ld;
    f_bits = 16'd0; f_nrise = 0; f_busy = 0; f_first_rise = 0; f_ld_low = 0;
    f_novr = 0; f_ovr_idx = 0; f_ndone = 0; f_cs_rise_idx = 0; f_ld_fall_idx = 0; f_timeout = 1;
    prev_sck = 1'b0; prev_cs = 1'b0; prev_ld = 1'b1;
    for (int idx = 1; idx < 300; idx++) begin
      if (idx > 1 && done) begin
        f_ndone++;
        f_timeout = 0;
        break;
      end
      if (busy) f_busy++;
      if (overrun) begin
        f_novr++;
        if (f_ovr_idx == 0) f_ovr_idx = idx;
      end
      if (dac_sck && !prev_sck && !dac_cs) begin
        f_bits = {f_bits[14:0], dac_sdi};
        f_nrise++;
        if (f_first_rise == 0) f_first_rise = idx;
      end
      if (!dac_ld) f_ld_low++;
      if (dac_cs && !prev_cs && f_cs_rise_idx == 0) f_cs_rise_idx = idx;
      if (!dac_ld && prev_ld && f_ld_fall_idx == 0) f_ld_fall_idx = idx;
      prev_sck = dac_sck; prev_cs = dac_cs; prev_ld = dac_ld;
      if (idx == inj1) begin data_in = d1; load = 1'b1; end
      else if (idx == inj2) begin data_in = d2; load = 1'b1; end
      else load = 1'b0;
      tick();
    end
    load = 1'b0;
    chk("frame_timeout", f_timeout, 0);
  endtask

  initial begin
    int b_busy, b_done, b_ovr, b_rises, b_badper, b_last_rise;
    logic b_prev_sck;

    reset = 1'b1; load = 1'b0; data_in = 10'd0; load_b = 1'b0; data_b = 10'd0;
    repeat (3) tick();
    chk("rst_cs", dac_cs, 1); chk("rst_sck", dac_sck, 0); chk("rst_sdi", dac_sdi, 0);
    chk("rst_ld", dac_ld, 1); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_overrun", overrun, 0);

    // Reset wins over a simultaneous load.
    load = 1'b1; data_in = 10'h2AA;
    tick();
    chk("rst_vs_load_busy", busy, 0); chk("rst_vs_load_cs", dac_cs, 1);
    reset = 1'b0; load = 1'b0;
    tick();

    // 0x2AA frame.
    do_load(10'h2AA);
    chk("f1_cs_low", dac_cs, 0); chk("f1_busy", busy, 1);
    watch(0, 10'd0, 0, 10'd0);
    chk("f1_bits", f_bits, 16'h3AA8); chk("f1_rises", f_nrise, 16);
    chk("f1_busy_cycles", f_busy, 70); chk("f1_first_rise", f_first_rise, 5);
    chk("f1_done", done, 1); chk("f1_busy_at_done", busy, 0);
    tick();
    chk("f1_done_width", done, 0);

    // All-zero and all-one samples.
    do_load(10'h000);
    watch(0, 10'd0, 0, 10'd0);
    chk("f0_bits", f_bits, 16'h3000); chk("f0_rises", f_nrise, 16);
    chk("f0_ld_low", f_ld_low, 2); chk("f0_ld_at_cs_rise", f_ld_fall_idx, f_cs_rise_idx);
    do_load(10'h3FF);
    watch(0, 10'd0, 0, 10'd0);
    chk("f3ff_bits", f_bits, 16'h3FFC); chk("f3ff_rises", f_nrise, 16);
    chk("f3ff_ld_low", f_ld_low, 2);
    tick();

    // One extra load during the frame.
    do_load(10'h155);
    watch(9, 10'h0F0, 0, 10'd0);
    chk("ov1_bits", f_bits, 16'h3554); chk("ov1_busy_cycles", f_busy, 70);
`ifdef DAC_LOAD_QUEUE_EN
    chk("ov1_novr", f_novr, 0);
    chk("ov1_q_busy", busy, 1);
    watch(0, 10'd0, 0, 10'd0);
    chk("ov1_q_bits", f_bits, 16'h33C0); chk("ov1_q_busy_cycles", f_busy, 70);
`else
    chk("ov1_novr", f_novr, 1); chk("ov1_ovr_idx", f_ovr_idx, 10);
`endif
    repeat (4) tick();
    chk("ov1_no_more_busy", busy, 0); chk("ov1_no_more_cs", dac_cs, 1);

    // Two extra loads during the frame.
    do_load(10'h155);
    watch(9, 10'h0F0, 20, 10'h30F);
    chk("ov2_bits", f_bits, 16'h3554);
`ifdef DAC_LOAD_QUEUE_EN
    chk("ov2_novr", f_novr, 1); chk("ov2_ovr_idx", f_ovr_idx, 21);
    watch(0, 10'd0, 0, 10'd0);
    chk("ov2_q_bits", f_bits, 16'h3C3C);
`else
    chk("ov2_novr", f_novr, 2);
`endif
    repeat (4) tick();
    chk("ov2_idle", busy, 0);

    // Reset during bit 7 (its rise would be sample 37).
    do_load(10'h2AA);
    repeat (35) tick();
    chk("mid_busy_before", busy, 1);
    reset = 1'b1;
    tick();
    chk("mid_cs", dac_cs, 1); chk("mid_sck", dac_sck, 0);
    chk("mid_ld", dac_ld, 1); chk("mid_busy", busy, 0);
    reset = 1'b0;
    tick();
    do_load(10'h2AA);
    watch(0, 10'd0, 0, 10'd0);
    chk("mid_after_bits", f_bits, 16'h3AA8); chk("mid_after_busy", f_busy, 70);
    tick();

    // CLK_DIV=1 instance, loads every 40 cycles.
    b_busy = 0; b_done = 0; b_ovr = 0; b_rises = 0; b_badper = 0; b_last_rise = -1; b_prev_sck = 1'b0;
    for (int i = 0; i < 120; i++) begin
      load_b = (i % 40 == 0);
      data_b = 10'(i * 7);
      tick();
      if (busy_b) b_busy++;
      if (done_b) b_done++;
      if (overrun_b) b_ovr++;
      if (sck_b && !b_prev_sck) begin
        b_rises++;
        if (b_last_rise >= 0 && (i - b_last_rise) != 2 && (i - b_last_rise) < 10) b_badper++;
        b_last_rise = i;
      end
      b_prev_sck = sck_b;
    end
    load_b = 1'b0;
    chk("b_busy_cycles", b_busy, 105); chk("b_done", b_done, 3);
    chk("b_overrun", b_ovr, 0); chk("b_rises", b_rises, 48);
    chk("b_sck_period", b_badper, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
